fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: data bus width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of storage entries, a power of two, 4..1024.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port wr_n, input, 1 bit: write request, active-low.
REQ-008 The block SHALL have port rd_n, input, 1 bit: read request, active-low.
REQ-009 The block SHALL have port clr_err, input, 1 bit: active-high clear for the sticky error flags.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: occupancy status decoded from count.
REQ-014 The block SHALL have ports over_flow and under_flow, each an output of 1 bit: one-cycle error pulses.
REQ-015 The block SHALL have ports ovf_sticky and unf_sticky, each an output of 1 bit: latched error flags.

Function
REQ-016 Write accept SHALL be: wr_n==0 and (count<DEPTH or rd accepted in the same cycle); on accept, data_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 Read accept SHALL be: rd_n==0 and count>0; on accept, data_out loads the entry at rd_ptr on the same clock edge (1-cycle latency) and rd_ptr increments modulo DEPTH.
REQ-018 data_out SHALL hold its previous value in any cycle without an accepted read.
REQ-019 count SHALL increment on a write-only accept, decrement on a read-only accept, and remain unchanged when both are accepted or neither is.
REQ-020 When full and both requests are low, both SHALL be accepted; the oldest entry is read, the new entry is written, and count stays DEPTH.
REQ-021 When empty and both requests are low, the read SHALL be rejected (under_flow pulses) and the write accepted; count becomes 1 and data_out is unchanged, with no fall-through.
REQ-022 over_flow SHALL be 1 for exactly the cycle following an edge at which wr_n==0 and the write was rejected; stored data and pointers are unchanged.
REQ-023 under_flow SHALL be 1 for exactly the cycle following an edge at which rd_n==0 and the read was rejected.
REQ-024 ovf_sticky (unf_sticky) SHALL set on the same edge that sets over_flow (under_flow), hold until clr_err==1, and on a simultaneous set and clear the set SHALL win.
REQ-025 Status outputs SHALL be derived combinationally from registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 without a gap, and FIFO ordering SHALL be preserved across any number of wraps.

Reset
REQ-027 When rst_n==0 at a rising clk edge, wr_ptr, rd_ptr and count SHALL clear to 0, data_out to 0, and over_flow, under_flow, ovf_sticky and unf_sticky to 0.
REQ-028 Reset SHALL take priority over wr_n, rd_n and clr_err, and any transfer in the same cycle SHALL be discarded.
REQ-029 After reset: empty=1, almost_empty=1, full=0, almost_full=0; storage contents SHALL NOT require clearing.
REQ-030 Reset asserted mid-operation, with the FIFO partly full, SHALL return the FIFO to the empty state with no residual data readable.

Verification (DATA_WIDTH=8, DEPTH=16, defaults)
REQ-031 Write 16..1 in 16 cycles -> count=16, full=1, almost_full asserted from count=14; two further writes -> over_flow pulses twice, ovf_sticky=1, count stays 16.
REQ-032 Then 16 reads -> data_out = 16,15,...,1, each valid one cycle after its read edge; empty=1; two more reads -> under_flow pulses twice, data_out holds 1, unf_sticky=1.
REQ-033 clr_err=1 for one cycle -> both sticky flags=0; clr_err=1 on the same cycle as a rejected write -> ovf_sticky=1.
REQ-034 On empty, wr_n=rd_n=0 with data 8 -> under_flow=1, count=1; the next read returns 8. On full, wr_n=rd_n=0 -> oldest word read, count stays 16, no over_flow.
REQ-035 Write 10 words, read 10, repeated 5 times (pointer wrap) -> output sequence equals input sequence, count returns to 0.
REQ-036 Write 5 words, assert rst_n=0 together with wr_n=0 -> count=0, empty=1, flags=0; a subsequent read gives under_flow=1.

Source files
------------

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with registered read data, occupancy status,
// one-cycle over/underflow pulses and sticky error flags.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_n,
    input  logic                        rd_n,
    input  logic                        clr_err,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        over_flow,
    output logic                        under_flow,
    output logic                        ovf_sticky,
    output logic                        unf_sticky
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  ovf_st_q, ovf_st_d;
    logic                  unf_st_q, unf_st_d;
    logic                  rd_acc, wr_acc;

    // Accept decode; a write into a full FIFO is allowed when a read frees a slot this cycle.
    always_comb begin
        rd_acc = !rd_n && (count_q != '0);
        wr_acc = !wr_n && ((count_q != DEPTH_C) || rd_acc);
    end

    // Next-state for pointers, occupancy, read data and error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = !wr_n && !wr_acc;
        unf_d    = !rd_n && !rd_acc;
        ovf_st_d = ovf_st_q;
        unf_st_d = unf_st_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem[rd_ptr_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        // Set beats clear when both happen together.
        if (clr_err) begin
            ovf_st_d = 1'b0;
            unf_st_d = 1'b0;
        end
        if (ovf_d) begin
            ovf_st_d = 1'b1;
        end
        if (unf_d) begin
            unf_st_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ovf_st_q <= 1'b0;
            unf_st_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ovf_st_q <= ovf_st_d;
            unf_st_q <= unf_st_d;
        end
    end

    // Storage array; not reset, and writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Outputs and status decoded from the registered occupancy.
    always_comb begin
        data_out     = dout_q;
        count        = count_q;
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        over_flow    = ovf_q;
        under_flow   = unf_q;
        ovf_sticky   = ovf_st_q;
        unf_sticky   = unf_st_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at DATA_WIDTH=8, DEPTH=16.
module tb_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       wr_n;
    logic       rd_n;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       over_flow, under_flow, ovf_sticky, unf_sticky;

    int errors = 0;
    int checks = 0;

    fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .clr_err     (clr_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .over_flow   (over_flow),
        .under_flow  (under_flow),
        .ovf_sticky  (ovf_sticky),
        .unf_sticky  (unf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; clr_err = 1'b0; data_in = '0;
        step();
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", almost_full); end
        checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", data_out); end
        checks++; if ({over_flow, under_flow, ovf_sticky, unf_sticky} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000",
                               {over_flow, under_flow, ovf_sticky, unf_sticky});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(16 - i); wr_n = 1'b0;
            step();
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 14)); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        for (int i = 0; i < 2; i++) begin
            data_in = 8'hEE;
            step();
            checks++; if (over_flow !== 1'b1) begin errors++; $display("FAIL ovf_pulse[%0d] got %b want 1", i, over_flow); end
            checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count[%0d] got %0d want 16", i, count); end
            checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b want 1", i, ovf_sticky); end
        end
        wr_n = 1'b1;
        step();
        checks++; if (over_flow !== 1'b0) begin errors++; $display("FAIL ovf_drop got %b want 0", over_flow); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", ovf_sticky); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            rd_n = 1'b0;
            step();
            checks++; if (data_out !== 8'(16 - i)) begin errors++; $display("FAIL drain_data[%0d] got %0d want %0d", i, data_out, 16 - i); end
            checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 15 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (under_flow !== 1'b1) begin errors++; $display("FAIL unf_pulse[%0d] got %b want 1", i, under_flow); end
            checks++; if (data_out !== 8'd1) begin errors++; $display("FAIL unf_hold[%0d] got %0d want 1", i, data_out); end
            checks++; if (unf_sticky !== 1'b1) begin errors++; $display("FAIL unf_sticky[%0d] got %b want 1", i, unf_sticky); end
        end
        rd_n = 1'b1;
        step();
        checks++; if (under_flow !== 1'b0) begin errors++; $display("FAIL unf_drop got %b want 0", under_flow); end
    endtask

    task automatic test_clear_errors();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if ({ovf_sticky, unf_sticky} !== 2'b00) begin errors++; $display("FAIL clr_sticky got %b want 00", {ovf_sticky, unf_sticky}); end
        // Refill with 100..115, then clear on the same cycle as a rejected write.
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(100 + i); wr_n = 1'b0;
            step();
        end
        data_in = 8'hAA; clr_err = 1'b1;
        step();
        wr_n = 1'b1; clr_err = 1'b0;
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", ovf_sticky); end
        checks++; if (over_flow !== 1'b1) begin errors++; $display("FAIL clr_ovf got %b want 1", over_flow); end
    endtask

    task automatic test_simul_full();
        wr_n = 1'b0; rd_n = 1'b0; data_in = 8'd200;
        step();
        wr_n = 1'b1;
        checks++; if (data_out !== 8'd100) begin errors++; $display("FAIL sfull_data got %0d want 100", data_out); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL sfull_count got %0d want 16", count); end
        checks++; if (over_flow !== 1'b0) begin errors++; $display("FAIL sfull_ovf got %b want 0", over_flow); end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (data_out !== ((i < 15) ? 8'(101 + i) : 8'd200)) begin
                errors++; $display("FAIL sfull_order[%0d] got %0d want %0d", i, data_out, (i < 15) ? 101 + i : 200);
            end
        end
        rd_n = 1'b1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sfull_empty got %b want 1", empty); end
    endtask

    task automatic test_simul_empty();
        wr_n = 1'b0; rd_n = 1'b0; data_in = 8'd8;
        step();
        wr_n = 1'b1;
        checks++; if (under_flow !== 1'b1) begin errors++; $display("FAIL sempty_unf got %b want 1", under_flow); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL sempty_count got %0d want 1", count); end
        checks++; if (data_out !== 8'd200) begin errors++; $display("FAIL sempty_nofall got %0d want 200", data_out); end
        step();
        rd_n = 1'b1;
        checks++; if (data_out !== 8'd8) begin errors++; $display("FAIL sempty_read got %0d want 8", data_out); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL sempty_count2 got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 10; i++) begin
                data_in = 8'(r * 10 + i + 1); wr_n = 1'b0;
                step();
            end
            wr_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
                rd_n = 1'b0;
                step();
                checks++; if (data_out !== 8'(r * 10 + i + 1)) begin
                    errors++; $display("FAIL wrap_data[%0d][%0d] got %0d want %0d", r, i, data_out, r * 10 + i + 1);
                end
            end
            rd_n = 1'b1;
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", count); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(60 + i); wr_n = 1'b0;
            step();
        end
        rst_n = 1'b0; data_in = 8'h55;
        step();
        rst_n = 1'b1; wr_n = 1'b1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b want 1", empty); end
        checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL mrst_dout got %0d want 0", data_out); end
        checks++; if ({over_flow, under_flow, ovf_sticky, unf_sticky} !== 4'b0) begin
            errors++; $display("FAIL mrst_flags got %b want 0000",
                               {over_flow, under_flow, ovf_sticky, unf_sticky});
        end
        rd_n = 1'b0;
        step();
        rd_n = 1'b1;
        checks++; if (under_flow !== 1'b1) begin errors++; $display("FAIL mrst_unf got %b want 1", under_flow); end
        checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL mrst_nodata got %0d want 0", data_out); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_clear_errors();
        test_simul_full();
        test_simul_empty();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
